// File: rtl/lcd_bus_arbiter_if.sv
// Write port of one requester into the character-LCD bus arbiter.
// The requester drives valid/rs/data/lock; the arbiter answers with ready.
interface lcd_bus_arbiter_if;
    logic       valid;
    logic       rs;
    logic [7:0] data;
    logic       lock;
    logic       ready;

    modport master (output valid, rs, data, lock, input ready);
    modport slave  (input valid, rs, data, lock, output ready);
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter and E-strobe timer for an HD44780-style LCD bus.
// Define LCD_ARB_LOCK_WDOG_EN to add the idle-lock watchdog (lock_timeout).
module lcd_bus_arbiter #(
    parameter int CNT1MS          = 100000,
    parameter int E_SETUP_MS      = 1,
    parameter int E_HIGH_MS       = 2,
    parameter int SLOT_MS         = 4,
    parameter int LONG_SLOT_MS    = 8,
    parameter int LOCK_TIMEOUT_MS = 20
) (
    input  logic             clk,
    input  logic             resetn,
    lcd_bus_arbiter_if.slave req0,
    lcd_bus_arbiter_if.slave req1,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic [7:0]       lcd_data,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             lock_timeout
);

    localparam int MS_MAX = (LONG_SLOT_MS > LOCK_TIMEOUT_MS) ?
                            LONG_SLOT_MS : LOCK_TIMEOUT_MS;
    localparam int CW     = $clog2(CNT1MS + 1);
    localparam int MW     = $clog2(MS_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt_clk, cnt_d;
    logic [MW-1:0]   ms_cnt, ms_d;
    logic            e_d, rs_d;
    logic [7:0]      data_d;
    logic [1:0]      grant_d;
    logic            lock, lock_d;
    logic            last, last_d;
    logic            sel0, sel1;
    logic            tick;
    logic            long_cmd;
    logic [MW-1:0]   slot_ms;
    logic            e_on, e_off, slot_end;

    assign lcd_rw     = 1'b0;
    assign busy       = (state != IDLE);
    assign req0.ready = sel0;
    assign req1.ready = sel1;

    assign tick     = (cnt_clk == CW'(CNT1MS - 1));
    assign long_cmd = !lcd_rs && (lcd_data inside {8'h01, 8'h02, 8'h03});
    assign slot_ms  = long_cmd ? MW'(LONG_SLOT_MS) : MW'(SLOT_MS);
    assign e_on     = tick && (ms_cnt == MW'(E_SETUP_MS - 1));
    assign e_off    = tick && (ms_cnt == MW'(E_SETUP_MS + E_HIGH_MS - 1));
    // Slot ends one cycle early so the next acceptance lands on T + S ms.
    assign slot_end = (ms_cnt == slot_ms - MW'(1)) &&
                      (cnt_clk == CW'(CNT1MS - 2));

    // last == 1 means requester 1 was served most recently.
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (state == IDLE) begin
            unique case (1'b1)
                lock: begin
                    sel0 = grant[0] & req0.valid;
                    sel1 = grant[1] & req1.valid;
                end
                !lock && req0.valid && req1.valid: begin
                    sel0 = last;
                    sel1 = !last;
                end
                !lock && !(req0.valid && req1.valid): begin
                    sel0 = req0.valid;
                    sel1 = req1.valid;
                end
            endcase
        end
    end

`ifdef LCD_ARB_LOCK_WDOG_EN
    logic wd_run;
    logic lto_q, lto_d;

    assign wd_run = (state == IDLE) && lock &&
                    ((grant[0] && !req0.valid) ||
                     (grant[1] && !req1.valid));
    assign lock_timeout = lto_q;
`else
    assign lock_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt_clk;
        ms_d    = ms_cnt;
        e_d     = lcd_e;
        rs_d    = lcd_rs;
        data_d  = lcd_data;
        grant_d = grant;
        lock_d  = lock;
        last_d  = last;
`ifdef LCD_ARB_LOCK_WDOG_EN
        lto_d   = 1'b0;
`endif
        if (state != IDLE) begin
            cnt_d = tick ? '0 : cnt_clk + CW'(1);
            ms_d  = tick ? ms_cnt + MW'(1) : ms_cnt;
        end
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                ms_d  = '0;
`ifdef LCD_ARB_LOCK_WDOG_EN
                if (wd_run) begin
                    cnt_d = tick ? '0 : cnt_clk + CW'(1);
                    ms_d  = tick ? ms_cnt + MW'(1) : ms_cnt;
                    if (tick && ms_cnt == MW'(LOCK_TIMEOUT_MS - 1)) begin
                        lock_d  = 1'b0;
                        grant_d = 2'b00;
                        lto_d   = 1'b1;
                        cnt_d   = '0;
                        ms_d    = '0;
                    end
                end
`endif
                if (sel0 || sel1) begin
                    rs_d    = sel1 ? req1.rs   : req0.rs;
                    data_d  = sel1 ? req1.data : req0.data;
                    lock_d  = sel1 ? req1.lock : req0.lock;
                    grant_d = {sel1, sel0};
                    last_d  = sel1;
                    cnt_d   = '0;
                    ms_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (e_on) begin
                    e_d     = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (e_off) begin
                    e_d     = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (slot_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ms_d    = '0;
                    if (!lock) grant_d = 2'b00;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt_clk  <= '0;
            ms_cnt   <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            grant    <= 2'b00;
            lock     <= 1'b0;
            last     <= 1'b1;
        end else begin
            state    <= state_d;
            cnt_clk  <= cnt_d;
            ms_cnt   <= ms_d;
            lcd_e    <= e_d;
            lcd_rs   <= rs_d;
            lcd_data <= data_d;
            grant    <= grant_d;
            lock     <= lock_d;
            last     <= last_d;
        end
    end

`ifdef LCD_ARB_LOCK_WDOG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lto_q <= 1'b0;
        else         lto_q <= lto_d;
    end
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: slot-time reference model
// compared every cycle, plus directed literal timing/arbitration checks.
module tb_lcd_bus_arbiter;
    localparam int C = 10, ES = 1, EH = 2, SL = 4, LS = 8, TO = 20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    lcd_bus_arbiter_if r0();
    lcd_bus_arbiter_if r1();
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [1:0] grant;
    logic       busy, lock_timeout;

    lcd_bus_arbiter #(
        .CNT1MS(C), .E_SETUP_MS(ES), .E_HIGH_MS(EH),
        .SLOT_MS(SL), .LONG_SLOT_MS(LS), .LOCK_TIMEOUT_MS(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .req0(r0), .req1(r1),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .grant(grant), .busy(busy),
        .lock_timeout(lock_timeout)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t",
                      name, act, exp, $time);
    endtask

    // Reference model: one slot = accept time + elapsed edges.
    bit         m_in, m_rs, m_lock, m_lto;
    int         m_e, m_s, m_own, m_last, m_wd;
    logic [7:0] m_data;

    function automatic int pick();
        if (!resetn || m_in) return -1;
        if (m_lock) return ((m_own == 0) ? r0.valid : r1.valid) ? m_own : -1;
        if (r0.valid && r1.valid) return (m_last == 0) ? 1 : 0;
        if (r0.valid) return 0;
        if (r1.valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        int s;
        if (!resetn) begin
            m_in = 0; m_e = 0; m_s = SL; m_own = 0; m_rs = 0;
            m_data = 8'h00; m_lock = 0; m_last = 1; m_wd = 0; m_lto = 0;
        end else begin
            s = pick();
            m_lto = 0;
            if (m_in) begin
                m_e++;
                m_wd = 0;
                if (m_e == m_s * C - 1) m_in = 0;
            end else if (s >= 0) begin
                m_in = 1; m_e = 0; m_own = s; m_last = s; m_wd = 0;
                m_rs   = s ? r1.rs   : r0.rs;
                m_data = s ? r1.data : r0.data;
                m_lock = s ? r1.lock : r0.lock;
                m_s = (!m_rs && m_data >= 1 && m_data <= 3) ? LS : SL;
            end else if (m_lock) begin
`ifdef LCD_ARB_LOCK_WDOG_EN
                m_wd++;
                if (m_wd == TO * C) begin
                    m_lock = 0; m_lto = 1; m_wd = 0;
                end
`endif
            end else begin
                m_wd = 0;
            end
        end
    end

    int  cyc = 0;
    int  acc_who[$], acc_t[$], rise_t[$], fall_t[$];
    bit  e_prev = 0;
    bit  phase_d = 0;
    int  r1rdy_cnt = 0;
    int  lto_t = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resetn) begin
            chk("ready0", r0.ready, pick() == 0);
            chk("ready1", r1.ready, pick() == 1);
            chk("busy", busy, m_in);
            chk("lcd_e", lcd_e, m_in && m_e >= ES * C && m_e < (ES + EH) * C);
            chk("lcd_rs", lcd_rs, m_rs);
            chk("lcd_data", lcd_data, m_data);
            chk("grant", grant, (m_in || m_lock) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
            chk("lock_timeout", lock_timeout, m_lto);
            chk("lcd_rw", lcd_rw, 0);
            if (r0.valid && r0.ready) begin acc_who.push_back(0); acc_t.push_back(cyc + 1); end
            if (r1.valid && r1.ready) begin acc_who.push_back(1); acc_t.push_back(cyc + 1); end
            if (lcd_e && !e_prev) rise_t.push_back(cyc);
            if (!lcd_e && e_prev) fall_t.push_back(cyc);
            if (lock_timeout) lto_t = cyc;
            if (phase_d && r1.ready) r1rdy_cnt++;
        end
        e_prev = lcd_e;
    end

    task automatic do_reset();
        resetn = 0;
        r0.valid = 0; r0.rs = 0; r0.data = 0; r0.lock = 0;
        r1.valid = 0; r1.rs = 0; r1.data = 0; r1.lock = 0;
        repeat (2) @(negedge clk);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lto", lock_timeout, 0);
        chk("rst_rdy0", r0.ready, 0);
        chk("rst_rdy1", r1.ready, 0);
        @(posedge clk); #1 resetn = 1;
    endtask

    task automatic write(input int r, input bit rs, input bit [7:0] d,
                         input bit lk, input bit drop);
        bit done = 0;
        if (r == 0) begin r0.valid = 1; r0.rs = rs; r0.data = d; r0.lock = lk; end
        else        begin r1.valid = 1; r1.rs = rs; r1.data = d; r1.lock = lk; end
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if ((r == 0) ? r0.ready : r1.ready) done = 1;
        end
        @(posedge clk); #1;
        if (drop) begin
            if (r == 0) r0.valid = 0; else r1.valid = 0;
        end
        if (!done) chk("write_timeout", 0, 1);
    endtask

    task automatic wait_acc(input int n);
        int i = 0;
        while (acc_t.size() < n && i < 3000) begin @(negedge clk); i++; end
        if (acc_t.size() < n) chk("acc_timeout", acc_t.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int i = 0;
        do begin @(negedge clk); i++; end while (busy && i < 3000);
        if (busy) chk("idle_timeout", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int b, rb, fb, n0, t;

        // Normal data write: strobe timing and 4 ms slot spacing.
        do_reset();
        b = acc_t.size(); rb = rise_t.size(); fb = fall_t.size();
        write(0, 1, 8'h41, 0, 0);
        @(negedge clk);
        chk("A_rs", lcd_rs, 1);
        chk("A_data", lcd_data, 8'h41);
        write(0, 1, 8'h41, 0, 1);
        chk("A_gap", acc_t[b+1] - acc_t[b], 40);
        chk("A_rise", rise_t[rb] - acc_t[b], 10);
        chk("A_fall", fall_t[fb] - acc_t[b], 30);
        wait_idle();

        // Clear-display command uses the long slot.
        b = acc_t.size(); rb = rise_t.size(); fb = fall_t.size();
        write(1, 0, 8'h01, 0, 0);
        write(1, 0, 8'h01, 0, 1);
        chk("B_gap", acc_t[b+1] - acc_t[b], 80);
        chk("B_rise", rise_t[rb] - acc_t[b], 10);
        chk("B_fall", fall_t[fb] - acc_t[b], 30);
        wait_idle();

        // Round robin with both requesters continuously valid.
        do_reset();
        b = acc_t.size();
        r0.data = 8'h30; r0.rs = 1; r1.data = 8'h31; r1.rs = 1;
        r0.valid = 1; r1.valid = 1;
        wait_acc(b + 4);
        r0.valid = 0; r1.valid = 0;
        for (int i = 0; i < 4; i++) chk("C_order", acc_who[b+i], i % 2);
        wait_idle();

        // Locked 17-write sequence holds off requester 1.
        do_reset();
        b = acc_t.size();
        r1.rs = 1; r1.data = 8'h55; r1.lock = 0; r1.valid = 1;
        phase_d = 1;
        for (int i = 0; i < 17; i++)
            write(0, 1, 8'(8'h40 + i), i != 16, i == 16);
        phase_d = 0;
        wait_acc(b + 18);
        r1.valid = 0;
        n0 = 0;
        while (n0 < 18 && acc_who[b+n0] == 0) n0++;
        chk("D_lead0", n0, 17);
        chk("D_next", acc_who[b+17], 1);
        chk("D_r1rdy", r1rdy_cnt, 0);
        wait_idle();

        // Asynchronous reset in the middle of the E pulse.
        do_reset();
        write(0, 1, 8'h41, 0, 1);
        t = acc_t[acc_t.size()-1];
        while (cyc < t + 15) @(negedge clk);
        chk("E_pulse", lcd_e, 1);
        r1.rs = 1; r1.data = 8'h99; r1.valid = 1;
        #1 resetn = 0;
        #1;
        chk("E_rst_e", lcd_e, 0);
        chk("E_rst_busy", busy, 0);
        chk("E_rst_grant", grant, 0);
        @(posedge clk); #1 resetn = 1;
        b = acc_t.size();
        wait_acc(b + 1);
        r1.valid = 0;
        chk("E_first", acc_who[b], 1);
        wait_idle();

`ifdef LCD_ARB_LOCK_WDOG_EN
        // Idle lock released by the watchdog; pending requester 1 follows.
        do_reset();
        write(0, 1, 8'h41, 1, 1);
        t = acc_t[acc_t.size()-1];
        r1.rs = 1; r1.data = 8'h22; r1.valid = 1;
        b = acc_t.size();
        wait_acc(b + 1);
        r1.valid = 0;
        chk("W_lto_t", lto_t - t, 239);
        chk("W_who", acc_who[b], 1);
        chk("W_next", acc_t[b] - lto_t, 1);
        wait_idle();
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            r0.valid = ($urandom_range(0, 1) == 1);
            r0.rs    = 1'($urandom_range(0, 1));
            r0.data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            r0.lock  = ($urandom_range(0, 9) < 3);
            r1.valid = ($urandom_range(0, 1) == 1);
            r1.rs    = 1'($urandom_range(0, 1));
            r1.data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            r1.lock  = ($urandom_range(0, 9) < 3);
        end
        r0.valid = 0; r1.valid = 0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
